button_conditioner: RTL and testbench

Conditions the two raw scoreboard push-buttons (up, down) into clean single-cycle count pulses for the downstream 0–99 score counter. Each button is synchronised, debounced, and edge-detected in one clock domain. Only the press event of each button produces a pulse. If both buttons complete debouncing on the same clock edge, both pulses are suppressed so the counter never sees conflicting commands.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the scoreboard
// up/down push-buttons, producing one clean pulse per accepted press.
// Presses that finish debouncing on the same edge cancel each other.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_up_i,
  input  logic btn_down_i,
  output logic up_o,
  output logic down_o,
  output logic up_held_o,
  output logic down_held_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);

  // Held level is the top state bit: PRESSED and RELEASE_PENDING both have it set.
  typedef enum logic [1:0] {
    RELEASED        = 2'b00,
    PRESS_PENDING   = 2'b01,
    PRESSED         = 2'b10,
    RELEASE_PENDING = 2'b11
  } state_e;

  // Channel 0 is the up button, channel 1 the down button.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] cnt_inc [2];
  logic [1:0]       press_q, press_d;
  logic             up_q, up_d;
  logic             down_q, down_d;

  // Two-flop synchroniser chain for both raw buttons.
  always_comb begin
    sync1_d = {btn_down_i, btn_up_i};
    sync2_d = sync1_q;
  end

  // Per-channel debounce FSM; any disagreeing sample during a pending state restarts it.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      cnt_inc[ch] = cnt_q[ch] + CNT_W'(1);
      press_d[ch] = 1'b0;
      case (state_q[ch])
        RELEASED: begin
          if (sync2_q[ch]) begin
            state_d[ch] = PRESS_PENDING;
            cnt_d[ch]   = CNT_W'(1);
          end
        end
        PRESS_PENDING: begin
          if (!sync2_q[ch]) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else if (cnt_inc[ch] == CNT_TERM) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
            press_d[ch] = 1'b1;
          end else begin
            cnt_d[ch]   = cnt_inc[ch];
          end
        end
        PRESSED: begin
          if (!sync2_q[ch]) begin
            state_d[ch] = RELEASE_PENDING;
            cnt_d[ch]   = CNT_W'(1);
          end
        end
        RELEASE_PENDING: begin
          if (sync2_q[ch]) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
          end else if (cnt_inc[ch] == CNT_TERM) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch]   = cnt_inc[ch];
          end
        end
        default: begin
          state_d[ch] = RELEASED;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  // Pulse generation: a press coinciding with the other button's press is dropped.
  always_comb begin
    up_d   = press_q[0] & ~press_q[1];
    down_d = press_q[1] & ~press_q[0];
  end

  // All state registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= RELEASED;
        cnt_q[ch]   <= '0;
      end
      press_q <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      press_q <= press_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign up_o        = up_q;
  assign down_o      = down_q;
  assign up_held_o   = state_q[0][1];
  assign down_held_o = state_q[1][1];

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus randomized bouncing,
// every cycle compared against a behavioural debounce model.
module tb_button_conditioner;

  localparam int D = 4;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b1;
  logic btn_up_i = 1'b0;
  logic btn_down_i = 1'b0;
  logic up_o, down_o, up_held_o, down_held_o;

  int checks_total = 0;
  int checks_passed = 0;
  int up_pulses = 0;
  int down_pulses = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .btn_up_i    (btn_up_i),
    .btn_down_i  (btn_down_i),
    .up_o        (up_o),
    .down_o      (down_o),
    .up_held_o   (up_held_o),
    .down_held_o (down_held_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
  endtask

  // Drive both raw buttons on the falling edge so the next rising edge is E0.
  task automatic applyStimulus(input logic up, input logic dn);
    @(negedge clk_i);
    btn_up_i   = up;
    btn_down_i = dn;
  endtask

  // Release both buttons and wait long enough for any debounce to finish.
  task automatic settle();
    applyStimulus(1'b0, 1'b0);
    repeat (2 * D + 6) @(posedge clk_i);
  endtask

  // Behavioural model: each button's samples reach the logic two edges late; the
  // accepted level flips after D consecutive samples disagreeing with it, and a
  // 0->1 flip is a press whose pulse appears one edge later unless both pressed.
  bit   q_up[$];
  bit   q_dn[$];
  bit   smp[2];
  logic lvl[2] = '{1'b0, 1'b0};
  int   run[2] = '{0, 0};
  logic ev[2];
  logic pend_up = 1'b0, pend_dn = 1'b0;
  logic exp_up = 1'b0, exp_dn = 1'b0, exp_hu = 1'b0, exp_hd = 1'b0;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_up.delete(); q_dn.delete();
      q_up.push_back(1'b0); q_up.push_back(1'b0);
      q_dn.push_back(1'b0); q_dn.push_back(1'b0);
      lvl[0] = 1'b0; lvl[1] = 1'b0; run[0] = 0; run[1] = 0;
      pend_up = 1'b0; pend_dn = 1'b0;
      exp_up = 1'b0; exp_dn = 1'b0; exp_hu = 1'b0; exp_hd = 1'b0;
    end else begin
      q_up.push_back(btn_up_i);
      q_dn.push_back(btn_down_i);
      smp[0] = q_up.pop_front();
      smp[1] = q_dn.pop_front();
      for (int ch = 0; ch < 2; ch++) begin
        ev[ch] = 1'b0;
        if (smp[ch] != lvl[ch]) begin
          run[ch]++;
          if (run[ch] == D) begin
            lvl[ch] = smp[ch];
            run[ch] = 0;
            ev[ch]  = smp[ch];
          end
        end else begin
          run[ch] = 0;
        end
      end
      exp_up  = pend_up;
      exp_dn  = pend_dn;
      pend_up = ev[0] & ~ev[1];
      pend_dn = ev[1] & ~ev[0];
      exp_hu  = lvl[0];
      exp_hd  = lvl[1];
    end
  end

  // Cycle monitor: compare against the model shortly after every rising edge.
  always @(posedge clk_i) begin
    #1;
    checkOutput("mdl_up_o", up_o, exp_up);
    checkOutput("mdl_down_o", down_o, exp_dn);
    checkOutput("mdl_up_held", up_held_o, exp_hu);
    checkOutput("mdl_down_held", down_held_o, exp_hd);
    checkOutput("never_both", up_o & down_o, 1'b0);
    if (up_o) up_pulses++;
    if (down_o) down_pulses++;
  end

  int rem_up, rem_dn;
  logic val_up, val_dn;

  initial begin
    // Reset state, applied asynchronously before any clock edge.
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("rst_up_o", up_o, 1'b0);
    checkOutput("rst_down_o", down_o, 1'b0);
    checkOutput("rst_up_held", up_held_o, 1'b0);
    checkOutput("rst_down_held", down_held_o, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;

    // Clean up press: pulse only after E6, held from E5.
    applyStimulus(1'b1, 1'b0);
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk_i); #1;
      checkOutput("t1_up_o", up_o, (e == 6));
      checkOutput("t1_up_held", up_held_o, (e >= 5));
      checkOutput("t1_down_o", down_o, 1'b0);
    end

    // Bouncing press: pulse six edges after the first stable-high sample.
    settle();
    up_pulses = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk_i); #1;
      checkOutput("t2_up_o", up_o, (e == 6));
    end
    @(negedge clk_i);
    checkOutput("t2_pulses", up_pulses, 1);

    // Coincident presses cancel; a later up re-press pulses normally.
    settle();
    up_pulses = 0; down_pulses = 0;
    applyStimulus(1'b1, 1'b1);
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("t3_up_pulses", up_pulses, 0);
    checkOutput("t3_down_pulses", down_pulses, 0);
    checkOutput("t3_up_held", up_held_o, 1'b1);
    checkOutput("t3_down_held", down_held_o, 1'b1);
    applyStimulus(1'b0, 1'b1);
    repeat (10) @(posedge clk_i);
    applyStimulus(1'b1, 1'b1);
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("t3_repress_up", up_pulses, 1);
    checkOutput("t3_repress_down", down_pulses, 0);

    // Up held, down pressed ten cycles later: one pulse each.
    settle();
    up_pulses = 0; down_pulses = 0;
    applyStimulus(1'b1, 1'b0);
    repeat (10) @(posedge clk_i);
    applyStimulus(1'b1, 1'b1);
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("t4_up_pulses", up_pulses, 1);
    checkOutput("t4_down_pulses", down_pulses, 1);

    // Reset at E3 of a press with the button still held.
    settle();
    applyStimulus(1'b1, 1'b0);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b0;
    #1;
    checkOutput("t5_rst_up_o", up_o, 1'b0);
    checkOutput("t5_rst_up_held", up_held_o, 1'b0);
    @(negedge clk_i) rst_n_i = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk_i); #1;
      checkOutput("t5_up_o", up_o, (e == 6));
    end

    // Reset while the pulse is high drops it immediately; the held button re-pulses once.
    settle();
    applyStimulus(1'b1, 1'b0);
    repeat (7) @(posedge clk_i);
    #1 checkOutput("t5b_pulse_high", up_o, 1'b1);
    #1 rst_n_i = 1'b0;
    #1;
    checkOutput("t5b_pulse_drop", up_o, 1'b0);
    checkOutput("t5b_held_drop", up_held_o, 1'b0);
    @(negedge clk_i) rst_n_i = 1'b1;
    up_pulses = 0;
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("t5b_pulses", up_pulses, 1);

    // Long hold with a short release glitch: one pulse, held never drops.
    settle();
    up_pulses = 0;
    applyStimulus(1'b1, 1'b0);
    repeat (100) @(posedge clk_i);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checkOutput("t6_held_low", up_held_o, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      checkOutput("t6_held_after", up_held_o, 1'b1);
    end
    @(negedge clk_i);
    checkOutput("t6_pulses", up_pulses, 1);

    // Randomized bouncing on both buttons with occasional resets; the model checks every cycle.
    settle();
    rem_up = 0; rem_dn = 0; val_up = 1'b0; val_dn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (rem_up == 0) begin
        val_up = 1'($urandom_range(0, 1));
        rem_up = $urandom_range(1, 3 * D);
      end
      if (rem_dn == 0) begin
        val_dn = 1'($urandom_range(0, 1));
        rem_dn = $urandom_range(1, 3 * D);
      end
      rem_up--; rem_dn--;
      applyStimulus(val_up, val_dn);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n_i = 1'b0;
        @(negedge clk_i) rst_n_i = 1'b1;
      end
    end
    settle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
